mc_bank_param: RTL

- Parametrised successor of the single-channel auto-increment memory controller.
- Single-port word memory with an internal address pointer. Each qualified cycle the pointer performs either a write or a registered read, and optionally post-increments.
- Adds the following over the previous generation:
  - explicit data-valid qualifier, in place of the high-impedance data check
  - direct address load
  - read-valid strobe
  - selectable wrap or saturate end-of-range handling
  - non-power-of-two depth
- Sits between a bus-side sequencer and downstream datapath consumers.

---
 rtl/mc_bank_param_if.sv | 35 +++
 rtl/mc_bank_param.sv | 136 +++++++++++++
 2 files changed

// File: rtl/mc_bank_param_if.sv
// mc_bank_param bus bundle: request side (En/WE/Inc/data/load/parity inject)
// and response side (pointer, read data, status pulses). master drives requests.
interface mc_bank_param_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic          En;
    logic          WE;
    logic          Inc;
    logic [DW-1:0] DataIn;
    logic          DataInValid;
    logic          LoadAddr;
    logic [AW-1:0] AddrIn;
    logic          ParInject;

    logic [AW-1:0] Addr;
    logic [DW-1:0] DOut;
    logic          DOutValid;
    logic          Last;
    logic          WrapPulse;
    logic          AddrErr;
    logic          ParErr;

    modport master (
        output En, WE, Inc, DataIn, DataInValid, LoadAddr, AddrIn, ParInject,
        input  Addr, DOut, DOutValid, Last, WrapPulse, AddrErr, ParErr
    );

    modport slave (
        input  En, WE, Inc, DataIn, DataInValid, LoadAddr, AddrIn, ParInject,
        output Addr, DOut, DOutValid, Last, WrapPulse, AddrErr, ParErr
    );
endinterface

// File: rtl/mc_bank_param.sv
// mc_bank_param: single-port word memory with an auto-incrementing pointer.
// Ports: clock, Reset (sync, active-high), bus (mc_bank_param_if.slave):
//   in : En, WE, Inc, DataIn, DataInValid, LoadAddr, AddrIn, ParInject
//   out: Addr, DOut, DOutValid, Last, WrapPulse, AddrErr, ParErr (all registered)
// Define MC_BANK_PARITY_EN to store a per-word even-parity bit and flag
// mismatches on read; otherwise ParErr is 0 and ParInject is ignored.
module mc_bank_param #(
    parameter int DW        = 8,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 1
) (
    input logic            clock,
    input logic            Reset,
    mc_bank_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [AW:0]   DepthVal = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] addrQ;
    logic [DW-1:0] dOutQ;
    logic          dOutValidQ;
    logic          lastQ;
    logic          wrapQ;
    logic          addrErrQ;
    logic          parErrQ;

    logic          atEnd;
    logic          loadOk;
    logic          doWrite;
    logic          doRead;
    logic [AW-1:0] addrStep;
    logic          wrapStep;
    logic [AW-1:0] addrNext;
    logic          wrapNext;

    assign atEnd   = (addrQ == LastAddr);
    assign loadOk  = ({1'b0, bus.AddrIn} < DepthVal);
    // LoadAddr suppresses any memory access in the same cycle.
    assign doWrite = !bus.LoadAddr && bus.En && bus.WE && bus.DataInValid;
    assign doRead  = !bus.LoadAddr && bus.En && !bus.WE;

    // Pointer value after one advance; saturate mode simply holds at the end.
    always_comb begin
        addrStep = addrQ;
        wrapStep = 1'b0;
        if (atEnd) begin
            if (WRAP_MODE != 0) begin
                addrStep = '0;
                wrapStep = 1'b1;
            end
        end else begin
            addrStep = addrQ + AW'(1);
        end
    end

    always_comb begin
        addrNext = addrQ;
        wrapNext = 1'b0;
        if (bus.LoadAddr) begin
            if (loadOk) begin
                addrNext = bus.AddrIn;
            end
        end else if ((doWrite || doRead) && bus.Inc) begin
            addrNext = addrStep;
            wrapNext = wrapStep;
        end
    end

    // Memory array has no reset; a reset cycle only blocks the write.
    always_ff @(posedge clock) begin
        if (!Reset && doWrite) begin
            mem[addrQ] <= bus.DataIn;
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            addrQ      <= '0;
            dOutQ      <= '0;
            dOutValidQ <= 1'b0;
            lastQ      <= 1'b0;
            wrapQ      <= 1'b0;
            addrErrQ   <= 1'b0;
        end else begin
            addrQ      <= addrNext;
            lastQ      <= (addrNext == LastAddr);
            wrapQ      <= wrapNext;
            addrErrQ   <= bus.LoadAddr && !loadOk;
            dOutValidQ <= doRead;
            if (doRead) begin
                dOutQ <= mem[addrQ];
            end
        end
    end

`ifdef MC_BANK_PARITY_EN
    logic memPar [DEPTH];

    always_ff @(posedge clock) begin
        if (!Reset && doWrite) begin
            memPar[addrQ] <= (^bus.DataIn) ^ bus.ParInject;
        end
    end

    // Checked against the word actually read, so the flag lines up with DOutValid.
    always_ff @(posedge clock) begin
        if (Reset) begin
            parErrQ <= 1'b0;
        end else begin
            parErrQ <= doRead && (memPar[addrQ] != (^mem[addrQ]));
        end
    end
`else
    logic unusedParInject;
    assign unusedParInject = bus.ParInject;

    always_ff @(posedge clock) begin
        if (Reset) begin
            parErrQ <= 1'b0;
        end else begin
            parErrQ <= 1'b0;
        end
    end
`endif

    assign bus.Addr      = addrQ;
    assign bus.DOut      = dOutQ;
    assign bus.DOutValid = dOutValidQ;
    assign bus.Last      = lastQ;
    assign bus.WrapPulse = wrapQ;
    assign bus.AddrErr   = addrErrQ;
    assign bus.ParErr    = parErrQ;
endmodule
